// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined integer ALU with valid/ready handshakes on
// both sides and full backpressure.
//
//   S1 registers the operand beat (a, b, ifun, set_cc).
//   S2 registers the computed result and its flags.
//   The result leaves S2 through the out_valid/out_ready handshake.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  operand handshake; in_ready is combinational from out_ready
//   ifun               0=ADD, 1=SUB (b-a), 2=AND, 3=XOR, others give out=0
//   a, b               operands (WIDTH bits)
//   set_cc             beat updates the condition codes when delivered
//   out_valid/out_ready result handshake
//   out                result (WIDTH bits)
//   cc_zf/cc_sf/cc_of  condition-code register
//
// Build option
//   ALU_CC_EN  when defined, flag logic and the CC register are compiled in;
//              otherwise cc_* are tied to 0 and set_cc is ignored.
module alu_pipe #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    typedef enum logic [3:0] {
        FN_ADD = 4'd0,
        FN_SUB = 4'd1,
        FN_AND = 4'd2,
        FN_XOR = 4'd3
    } alu_fn_e;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_ifun;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_out;
    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] res;

    // S2 advances when empty or draining; S1 advances when empty or when its
    // beat moves into S2. No skid buffer, so in_ready follows out_ready.
    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;
    assign out       = s2_out;

    always_comb begin
        res = '0;
        case (s1_ifun)
            FN_ADD:  res = s1_a + s1_b;
            FN_SUB:  res = s1_b - s1_a;
            FN_AND:  res = s1_a & s1_b;
            FN_XOR:  res = s1_a ^ s1_b;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_ifun  <= '0;
            s2_valid <= 1'b0;
            s2_out   <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_out <= res;
                end
            end
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a    <= a;
                    s1_b    <= b;
                    s1_ifun <= ifun;
                end
            end
        end
    end

`ifdef ALU_CC_EN
    logic s1_set_cc;
    logic s2_zf;
    logic s2_sf;
    logic s2_of;
    logic s2_cc_upd;
    logic of_c;

    // Signed overflow: ADD when operand signs agree and the result sign
    // differs; SUB (b-a) when signs differ and the result sign leaves b's.
    always_comb begin
        of_c = 1'b0;
        case (s1_ifun)
            FN_ADD:  of_c = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (res[WIDTH-1] != s1_a[WIDTH-1]);
            FN_SUB:  of_c = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (res[WIDTH-1] != s1_b[WIDTH-1]);
            default: of_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_set_cc <= 1'b0;
            s2_zf     <= 1'b0;
            s2_sf     <= 1'b0;
            s2_of     <= 1'b0;
            s2_cc_upd <= 1'b0;
            cc_zf     <= 1'b1;
            cc_sf     <= 1'b0;
            cc_of     <= 1'b0;
        end else begin
            if (s1_load && in_valid) begin
                s1_set_cc <= set_cc;
            end
            if (s2_load && s1_valid) begin
                s2_zf     <= (res == '0);
                s2_sf     <= res[WIDTH-1];
                s2_of     <= of_c;
                // Invalid function codes never touch the CC register.
                s2_cc_upd <= s1_set_cc && (s1_ifun < 4'd4);
            end
            if (s2_valid && out_ready && s2_cc_upd) begin
                cc_zf <= s2_zf;
                cc_sf <= s2_sf;
                cc_of <= s2_of;
            end
        end
    end
`else
    logic unused_set_cc;
    assign unused_set_cc = set_cc;
    assign cc_zf = 1'b0;
    assign cc_sf = 1'b0;
    assign cc_of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=64). A queue of
// accepted beats models the pipeline contents; results and flags are derived
// from plain arithmetic on each beat. Works with ALU_CC_EN defined or not.
module tb_alu_pipe;

    localparam int W = 64;

`ifdef ALU_CC_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   ifun;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         set_cc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         cc_zf;
    logic         cc_sf;
    logic         cc_of;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ifun(ifun), .a(a), .b(b), .set_cc(set_cc),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   fn;
        logic         sc;
    } beat_t;

    beat_t q[$];
    bit    last_acc = 1'b0;
    logic  m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;

    function automatic logic [W-1:0] ref_out(beat_t t);
        case (t.fn)
            4'd0:    return t.a + t.b;
            4'd1:    return t.b - t.a;
            4'd2:    return t.a & t.b;
            4'd3:    return t.a ^ t.b;
            default: return '0;
        endcase
    endfunction

    // Overflow via a sign-extended W+1 bit result whose top two bits disagree.
    function automatic logic [2:0] ref_flags(beat_t t);
        logic [W-1:0] r;
        logic [W:0]   wide;
        logic         ovf;
        r    = ref_out(t);
        ovf  = 1'b0;
        wide = '0;
        if (t.fn == 4'd0) begin
            wide = {t.a[W-1], t.a} + {t.b[W-1], t.b};
            ovf  = wide[W] != wide[W-1];
        end else if (t.fn == 4'd1) begin
            wide = {t.b[W-1], t.b} - {t.a[W-1], t.a};
            ovf  = wide[W] != wide[W-1];
        end
        return {r == '0, r[W-1], ovf};
    endfunction

    function automatic logic [2:0] exp_cc();
        return CC_EN ? {m_zf, m_sf, m_of} : 3'b000;
    endfunction

    function automatic logic [2:0] mask_cc(logic [2:0] f);
        return CC_EN ? f : 3'b000;
    endfunction

    // One clock: samples both handshakes just before the edge and advances the
    // model. A delivery the model does not expect returns dexp = X.
    task automatic tick(output bit del, output logic [W-1:0] dout, output logic [W-1:0] dexp);
        bit    acc;
        bit    r;
        beat_t nb;
        beat_t hd;
        #1;
        r    = (rst === 1'b1);
        acc  = in_valid && in_ready;
        del  = out_valid && out_ready;
        dout = out;
        dexp = '0;
        nb.a = a; nb.b = b; nb.fn = ifun; nb.sc = set_cc;
        @(posedge clk);
        if (r) begin
            q.delete();
            {m_zf, m_sf, m_of} = 3'b100;
            del      = 1'b0;
            last_acc = 1'b0;
        end else begin
            if (del) begin
                if (q.size() == 0) begin
                    dexp = 'x;
                end else begin
                    hd   = q.pop_front();
                    dexp = ref_out(hd);
                    if (hd.sc && hd.fn < 4'd4) {m_zf, m_sf, m_of} = ref_flags(hd);
                end
            end
            if (acc) q.push_back(nb);
            last_acc = acc;
        end
        @(negedge clk);
    endtask

    // Sends one beat into an empty pipe and waits (bounded) for its result.
    task automatic run_one(input logic [3:0] fn, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic sc, output bit got, output logic [W-1:0] dout,
                           output logic [W-1:0] dexp);
        bit d;
        logic [W-1:0] o, e;
        got = 1'b0; dout = '0; dexp = '0;
        out_ready = 1'b1; in_valid = 1'b1; ifun = fn; a = av; b = bv; set_cc = sc;
        tick(d, o, e);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick(d, o, e);
            if (d) begin got = 1'b1; dout = o; dexp = e; end
        end
    endtask

    task automatic test_reset();
        bit d;
        logic [W-1:0] o, e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ifun = '0; a = '0; b = '0; set_cc = 1'b0;
        tick(d, o, e);
        tick(d, o, e);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== {CC_EN, 2'b00}) begin
            errors++; $display("FAIL reset_cc: got %b expected %b", {cc_zf, cc_sf, cc_of}, {CC_EN, 2'b00});
        end
    endtask

    task automatic test_single_add();
        bit d;
        logic [W-1:0] o, e;
        out_ready = 1'b1; in_valid = 1'b1; ifun = 4'd0; a = 64'd5; b = 64'd7; set_cc = 1'b1;
        tick(d, o, e);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b expected 0", out_valid); end
        tick(d, o, e);
        checks++; if (out_valid !== 1'b1 || out !== 64'd12) begin
            errors++; $display("FAIL add_latency: got valid=%b out=%h expected valid=1 out=%h", out_valid, out, 64'd12);
        end
        checks++; if ({cc_zf, cc_sf, cc_of} !== {CC_EN, 2'b00}) begin
            errors++; $display("FAIL add_cc_before: got %b expected %b", {cc_zf, cc_sf, cc_of}, {CC_EN, 2'b00});
        end
        tick(d, o, e);
        checks++; if (!d || o !== e) begin errors++; $display("FAIL add_deliver: got del=%b out=%h expected %h", d, o, e); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin
            errors++; $display("FAIL add_cc_after: got %b expected 000", {cc_zf, cc_sf, cc_of});
        end
    endtask

    task automatic test_overflow();
        logic [3:0]   fns [3] = '{4'd0, 4'd1, 4'd1};
        logic [W-1:0] as  [3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd9};
        logic [W-1:0] bs  [3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd9};
        logic [W-1:0] rs  [3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0};
        logic [2:0]   fs  [3] = '{3'b011, 3'b001, 3'b100};
        bit got;
        logic [W-1:0] o, e;
        for (int i = 0; i < 3; i++) begin
            run_one(fns[i], as[i], bs[i], 1'b1, got, o, e);
            checks++; if (!got || o !== rs[i]) begin
                errors++; $display("FAIL ovf_out[%0d]: got del=%b out=%h expected %h", i, got, o, rs[i]);
            end
            checks++; if ({cc_zf, cc_sf, cc_of} !== mask_cc(fs[i])) begin
                errors++; $display("FAIL ovf_cc[%0d]: got %b expected %b", i, {cc_zf, cc_sf, cc_of}, mask_cc(fs[i]));
            end
        end
    endtask

    task automatic test_stream();
        bit d;
        logic [W-1:0] o, e;
        int n = 0, first = -1, last = -1, cyc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; ifun = (i % 2 == 1) ? 4'd3 : 4'd2;
            a = 64'hF0F0_F0F0_F0F0_F0F0; b = 64'hFF00_FF00_FF00_FF00; set_cc = 1'($urandom);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
            tick(d, o, e); cyc++;
            if (d) begin
                if (first < 0) first = cyc;
                last = cyc; n++;
                checks++; if (o !== e) begin errors++; $display("FAIL stream_out: got %h expected %h", o, e); end
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10 && q.size() != 0; k++) begin
            tick(d, o, e); cyc++;
            if (d) begin
                if (first < 0) first = cyc;
                last = cyc; n++;
                checks++; if (o !== e) begin errors++; $display("FAIL stream_out: got %h expected %h", o, e); end
            end
            checks++; if ({cc_zf, cc_sf, cc_of} !== exp_cc()) begin
                errors++; $display("FAIL stream_cc: got %b expected %b", {cc_zf, cc_sf, cc_of}, exp_cc());
            end
        end
        checks++; if (n != 8 || last - first != 7) begin
            errors++; $display("FAIL stream_count: got %0d beats over %0d cycles expected 8 over 8", n, last - first + 1);
        end
    endtask

    task automatic test_backpressure();
        bit pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bit d, hold, saw_full;
        logic [W-1:0] o, e, held;
        int sent = 0, n = 0;
        saw_full = 1'b0;
        for (int c = 0; c < 20; c++) begin
            out_ready = (c < 6) ? pat[c] : 1'b1;
            in_valid  = (sent < 4);
            ifun = 4'($urandom_range(0, 3)); a = {$urandom, $urandom}; b = {$urandom, $urandom}; set_cc = 1'b1;
            #1;
            checks++; if (in_ready !== ((q.size() < 2) || out_ready)) begin
                errors++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", c, in_ready, (q.size() < 2) || out_ready);
            end
            if (in_ready === 1'b0) saw_full = 1'b1;
            if (in_valid && in_ready) sent++;
            hold = out_valid && !out_ready;
            held = out;
            tick(d, o, e);
            if (hold) begin
                checks++; if (out_valid !== 1'b1 || out !== held) begin
                    errors++; $display("FAIL bp_hold: got valid=%b out=%h expected valid=1 out=%h", out_valid, out, held);
                end
            end
            if (d) begin
                n++;
                checks++; if (o !== e) begin errors++; $display("FAIL bp_out: got %h expected %h", o, e); end
            end
            checks++; if ({cc_zf, cc_sf, cc_of} !== exp_cc()) begin
                errors++; $display("FAIL bp_cc: got %b expected %b", {cc_zf, cc_sf, cc_of}, exp_cc());
            end
        end
        in_valid = 1'b0;
        checks++; if (n != 4 || !saw_full) begin
            errors++; $display("FAIL bp_count: got %0d beats full=%b expected 4 beats full=1", n, saw_full);
        end
    endtask

    task automatic test_invalid();
        bit got;
        logic [W-1:0] o, e, x;
        run_one(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, got, o, e);
        run_one(4'd7, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, got, o, e);
        checks++; if (!got || o !== '0) begin errors++; $display("FAIL inv_out: got del=%b out=%h expected 0", got, o); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== mask_cc(3'b011)) begin
            errors++; $display("FAIL inv_cc: got %b expected %b", {cc_zf, cc_sf, cc_of}, mask_cc(3'b011));
        end
        x = {$urandom, $urandom};
        run_one(4'd3, x, x, 1'b0, got, o, e);
        checks++; if (!got || o !== '0) begin errors++; $display("FAIL nocc_out: got del=%b out=%h expected 0", got, o); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== mask_cc(3'b011)) begin
            errors++; $display("FAIL nocc_cc: got %b expected %b", {cc_zf, cc_sf, cc_of}, mask_cc(3'b011));
        end
    endtask

    task automatic test_random();
        bit d;
        logic [W-1:0] o, e;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4 != 0);
            out_ready = ($urandom % 3 != 0);
            ifun = 4'($urandom_range(0, 5)); set_cc = 1'($urandom);
            a = ($urandom % 8 == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
            b = ($urandom % 8 == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            #1;
            checks++; if (in_ready !== ((q.size() < 2) || out_ready)) begin
                errors++; $display("FAIL rnd_in_ready: got %b expected %b", in_ready, (q.size() < 2) || out_ready);
            end
            checks++; if (out_valid !== ((q.size() == 2) || (q.size() == 1 && !last_acc))) begin
                errors++; $display("FAIL rnd_out_valid: got %b expected %b", out_valid,
                                   (q.size() == 2) || (q.size() == 1 && !last_acc));
            end
            tick(d, o, e);
            if (d) begin
                checks++; if (o !== e) begin errors++; $display("FAIL rnd_out: got %h expected %h", o, e); end
            end
            checks++; if ({cc_zf, cc_sf, cc_of} !== exp_cc()) begin
                errors++; $display("FAIL rnd_cc: got %b expected %b", {cc_zf, cc_sf, cc_of}, exp_cc());
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10 && q.size() != 0; k++) begin
            tick(d, o, e);
            if (d) begin
                checks++; if (o !== e) begin errors++; $display("FAIL rnd_out: got %h expected %h", o, e); end
            end
        end
        checks++; if (q.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_drain: got %0d pending valid=%b expected 0 pending valid=0", q.size(), out_valid);
        end
    endtask

    task automatic test_midreset();
        bit d, got;
        logic [W-1:0] o, e;
        run_one(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, got, o, e);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; ifun = 4'd1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; set_cc = 1'b1;
            tick(d, o, e);
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_full: got in_ready=%b out_valid=%b expected 0 1", in_ready, out_valid);
        end
        rst = 1'b1; out_ready = 1'b1;
        tick(d, o, e);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_valid: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        checks++; if ({cc_zf, cc_sf, cc_of} !== {CC_EN, 2'b00}) begin
            errors++; $display("FAIL mid_cc: got %b expected %b", {cc_zf, cc_sf, cc_of}, {CC_EN, 2'b00});
        end
        for (int k = 0; k < 5; k++) begin
            tick(d, o, e);
            checks++; if (d) begin errors++; $display("FAIL mid_ghost: got delivery %h expected none", o); end
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_add();
        test_overflow();
        test_stream();
        test_backpressure();
        test_invalid();
        test_random();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
